// File: rtl/program_counter.sv
// Architectural program counter with next-PC select for the single-cycle RV32 core.
// PC is a single register; PCPlus4 is a purely combinational adder off that register.
module program_counter #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4
);

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_TARGET = 2'b01,
    PC_JALR   = 2'b10,
    PC_HOLD   = 2'b11
  } pc_src_e;

  logic [XLEN-1:0] pc_next;

  // Wraps modulo 2^XLEN with no carry out.
  assign PCPlus4 = PC + XLEN'(4);

  // NOTE: pc_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    pc_next = PC;
    unique case (pc_src_e'(PCSrc))
      PC_SEQ:    pc_next = PCPlus4;
      PC_TARGET: pc_next = PCTarget;
      PC_JALR:   pc_next = {ALUResult[XLEN-1:1], 1'b0};
      PC_HOLD:   pc_next = PC;
      default:   pc_next = PC;
    endcase
  end

  // NOTE: Reset is synchronous here, so it sits inside the clocked branch, not the sensitivity list;
  // state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset) PC <= RESET_VECTOR;
    else       PC <= pc_next;
  end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed vector table, hand-written
// between-edge sequences, and randomized traffic against a behavioural model.
module tb_program_counter;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RST_V = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [1:0]  pcsrc;
  logic [31:0] pctarget;
  logic [31:0] aluresult;
  logic [31:0] pc;
  logic [31:0] pcplus4;

  int checks = 0;
  int errors = 0;

  program_counter #(.XLEN(XLEN), .RESET_VECTOR(RST_V)) dut (
    .CLK      (clk),
    .Reset    (reset),
    .PCSrc    (pcsrc),
    .PCTarget (pctarget),
    .ALUResult(aluresult),
    .PC       (pc),
    .PCPlus4  (pcplus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] s, input logic [31:0] t, input logic [31:0] a);
    reset     = r;
    pcsrc     = s;
    pctarget  = t;
    aluresult = a;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC computed from the architectural rules with wide arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic r,
                                             input logic [1:0] s, input logic [31:0] t,
                                             input logic [31:0] a);
    longint unsigned wide;
    if (r) return RST_V;
    case (s)
      2'd0: begin
        wide = (longint'(cur) + 64'd4) % 64'h1_0000_0000;
        return wide[31:0];
      end
      2'd1: return t;
      2'd2: return a - (a % 2);
      default: return cur;
    endcase
  endfunction

  vec_t vecs[$];

  initial begin
    logic [31:0] mpc;
    logic        r;
    logic [1:0]  s;
    logic [31:0] t, a;

    vecs.push_back('{1'b1, 2'd0, 32'h0,          32'h0,          32'h0000_0000, 32'h0000_0004});
    vecs.push_back('{1'b0, 2'd0, 32'h0,          32'h0,          32'h0000_0004, 32'h0000_0008});
    vecs.push_back('{1'b0, 2'd0, 32'h0,          32'h0,          32'h0000_0008, 32'h0000_000C});
    vecs.push_back('{1'b0, 2'd1, 32'h10,         32'h0,          32'h0000_0010, 32'h0000_0014});
    vecs.push_back('{1'b0, 2'd2, 32'h0,          32'h40,         32'h0000_0040, 32'h0000_0044});
    vecs.push_back('{1'b0, 2'd2, 32'h0,          32'h40,         32'h0000_0040, 32'h0000_0044});
    vecs.push_back('{1'b0, 2'd2, 32'h0,          32'h41,         32'h0000_0040, 32'h0000_0044});
    vecs.push_back('{1'b0, 2'd3, 32'h5555_0000,  32'h7777_0001,  32'h0000_0040, 32'h0000_0044});
    vecs.push_back('{1'b0, 2'd3, 32'h5555_0000,  32'h7777_0001,  32'h0000_0040, 32'h0000_0044});
    vecs.push_back('{1'b0, 2'd3, 32'h5555_0000,  32'h7777_0001,  32'h0000_0040, 32'h0000_0044});
    vecs.push_back('{1'b0, 2'd1, 32'hFFFF_FFFC,  32'h0,          32'hFFFF_FFFC, 32'h0000_0000});
    vecs.push_back('{1'b0, 2'd0, 32'h0,          32'h0,          32'h0000_0000, 32'h0000_0004});
    vecs.push_back('{1'b0, 2'd1, 32'h40,         32'h0,          32'h0000_0040, 32'h0000_0044});
    vecs.push_back('{1'b1, 2'd1, 32'h80,         32'h0,          32'h0000_0000, 32'h0000_0004});
    vecs.push_back('{1'b0, 2'd1, 32'h123,        32'h0,          32'h0000_0123, 32'h0000_0127});
    vecs.push_back('{1'b0, 2'd2, 32'h0,          32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0002});

    drive(1'b1, 2'd0, 32'h0, 32'h0);
    #2;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].src, vecs[i].tgt, vecs[i].alu);
      tick();
      check($sformatf("vec%0d pc", i),  pc,      vecs[i].exp_pc);
      check($sformatf("vec%0d pc4", i), pcplus4, vecs[i].exp_pc4);
    end

    // Target changes between edges must not reach PC before the next edge.
    drive(1'b0, 2'd1, 32'h10, 32'h0);
    tick();
    check("branch pc", pc, 32'h10);
    #2 pctarget = 32'h20;
    #1 check("branch midcycle hold", pc, 32'h10);
    check("branch midcycle pc4", pcplus4, 32'h14);
    tick();
    check("branch next edge", pc, 32'h20);

    // A reset pulse that does not straddle an edge leaves PC alone.
    drive(1'b0, 2'd3, 32'h0, 32'h0);
    tick();
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    #1 check("reset glitch no effect", pc, 32'h20);
    tick();
    check("reset glitch after edge", pc, 32'h20);

    // Randomized traffic against the model, starting from a clean reset.
    drive(1'b1, 2'd0, 32'h0, 32'h0);
    tick();
    mpc = RST_V;
    check("rand reset", pc, mpc);
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 15) == 0);
      s = 2'($urandom_range(0, 3));
      t = $urandom();
      a = $urandom();
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFFC;
      drive(r, s, t, a);
      mpc = model_next(mpc, r, s, t, a);
      tick();
      check($sformatf("rand%0d pc", n),  pc,      mpc);
      check($sformatf("rand%0d pc4", n), pcplus4, mpc + 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Architectural program-counter register and next-PC select for the single-cycle RV32 mini CPU.
- Holds the current fetch address (PC) and drives it to instruction memory.
- Each clock it loads one of three sources: sequential PC+4, branch/JAL target (PCTarget), or the JALR address (ALUResult).
- Also provides PC+4 for the writeback mux (link address).

Parameters:
- XLEN, 32, datapath/address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- PCSrc  input  2  next-PC select: 00 = PC+4, 01 = PCTarget, 10 = ALUResult (JALR), 11 = hold.
- PCTarget  input  XLEN  branch/JAL target address from the target adder.
- ALUResult  input  XLEN  computed JALR target from the ALU.
- PC  output  XLEN  current program counter (registered).
- PCPlus4  output  XLEN  PC + 4 (combinational).

Behaviour:
- One clock (CLK). Reset is synchronous and active-high, sampled on the rising edge of CLK.
- PC register:
  - Rising edge with Reset=1: PC <= RESET_VECTOR. Reset has priority over PCSrc.
  - No asynchronous path; asserting Reset between edges does not change PC until the next rising edge.
- Next-PC selection (Reset=0, rising edge):
  - PCSrc=00: PC <= PC + 4.
  - PCSrc=01: PC <= PCTarget, used verbatim.
  - PCSrc=10: PC <= {ALUResult[XLEN-1:1], 1'b0}. Bit 0 is cleared per RISC-V JALR semantics.
  - PCSrc=11: PC <= PC (hold/stall). This encoding is reserved and must not produce X.
- Latency: a PCSrc/PCTarget/ALUResult change takes effect on PC at the next rising edge, with exactly one cycle latency.
- Inputs are sampled only at the edge; changes between edges have no effect on PC.
- PCPlus4 is purely combinational: PC + 4.
  - It is valid in the same cycle PC changes, with no register stage.
  - Arithmetic is modulo 2^XLEN: PC = 32'hFFFF_FFFC gives PCPlus4 = 32'h0000_0000, and the sequential next PC wraps to 0 with no flag.
- No alignment checking on PCTarget; a misaligned target is loaded as given. Exception handling is outside this block.
- Before the first reset edge, PC is undefined. The system must assert Reset for at least one rising edge.
- Reset mid-operation: any PCSrc value is ignored on that edge, and PC returns to RESET_VECTOR.
- Outputs never depend combinationally on PCSrc, PCTarget or ALUResult.

Test Plan:
- Reset: Reset=1 across one rising edge, PCSrc=00 -> PC=0x00000000, PCPlus4=0x00000004.
- Sequential: Reset=0, PCSrc=00 for two edges from PC=0 -> PC=0x4 then 0x8; PCPlus4 tracks 0x8, 0xC.
- Branch: PCTarget=0x10, PCSrc=01, one edge -> PC=0x10. Change PCTarget to 0x20 mid-cycle -> PC unchanged until the next edge, then PC=0x20.
- JALR: PCSrc=10, ALUResult=0x40 -> PC=0x40 and stays 0x40 on further edges. ALUResult=0x41 -> PC=0x40 (bit 0 cleared).
- Hold and wrap: PCSrc=11 -> PC unchanged over 3 edges. PCTarget=0xFFFFFFFC loaded via PCSrc=01, then PCSrc=00 -> PCPlus4=0x0 and the next PC=0x0.
- Reset priority: PC=0x40, PCSrc=01, PCTarget=0x80, Reset=1 on the edge -> PC=0x0. Reset pulsed between edges without covering an edge -> PC unchanged.
